// File: rtl/rr_sel_seq.sv
// Round-robin select sequencer driving the 2-to-4 decoder selects with a bounded dwell per grant.
// Optional feature macro RR_SEL_GAP_EN: one idle cycle between grants (break-before-make).
module rr_sel_seq #(
  parameter int DWELL = 4,
  parameter int CW    = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [3:0] req,
  output logic       sel0,
  output logic       sel1,
  output logic       valid,
  output logic       done,
  output logic [1:0] dbg_state_o
);

  // Handshake: valid high means {sel1,sel0} is a live grant; there is no ready,
  // and the selects never move while valid is high except on a grant-start edge.

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CW-1:0] CNT_LOAD = CW'(DWELL - 1);

  state_t        state_q;
  logic [1:0]    sel_q;
  logic          valid_q;
  logic          done_q;
  logic [1:0]    last_q;
  logic [CW-1:0] cnt_q;

  logic [1:0]    arb_base;
  logic [1:0]    arb_idx;
  logic          arb_hit;
  logic          grant_exit;

  // During GRANT the arbitration base is the current select, since that is
  // what last becomes on the exit edge where a back-to-back grant is chosen.
  always_comb begin
    arb_base = (state_q == GRANT) ? sel_q : last_q;
    arb_idx  = arb_base;
    arb_hit  = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (!arb_hit && req[arb_base + 2'(k)]) begin
        arb_hit = 1'b1;
        arb_idx = arb_base + 2'(k);
      end
    end
  end

  assign grant_exit = (cnt_q == '0) || !req[sel_q] || !en;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sel_q   <= 2'd0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE, GAP: begin
          if (en && arb_hit) begin
            sel_q   <= arb_idx;
            valid_q <= 1'b1;
            cnt_q   <= CNT_LOAD;
            state_q <= GRANT;
          end else begin
            valid_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        GRANT: begin
          if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
          if (grant_exit) begin
            last_q <= sel_q;
            done_q <= 1'b1;
`ifdef RR_SEL_GAP_EN
            valid_q <= 1'b0;
            state_q <= GAP;
`else
            if (en && arb_hit) begin
              sel_q <= arb_idx;
              cnt_q <= CNT_LOAD;
            end else begin
              valid_q <= 1'b0;
              state_q <= IDLE;
            end
`endif
          end
        end
        default: begin
          valid_q <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign sel0        = sel_q[0];
  assign sel1        = sel_q[1];
  assign valid       = valid_q;
  assign done        = done_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_rr_sel_seq.sv
// Self-checking bench for rr_sel_seq: directed steps plus random traffic against a grant-level model.
module tb_rr_sel_seq;

  localparam int DWELL = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       sel0, sel1, valid, done;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;

  // Reference model: grant-level view (is a grant live, who holds it, cycles left).
  int m_valid = 0;
  int m_sel   = 0;
  int m_done  = 0;
  int m_last  = 3;
  int m_left  = 0;

  rr_sel_seq #(.DWELL(DWELL), .CW(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .req        (req),
    .sel0       (sel0),
    .sel1       (sel1),
    .valid      (valid),
    .done       (done),
    .dbg_state_o(dbg_state)
  );

  always #5 clk = ~clk;

  function automatic int pick(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_update();
    int w;
    if (rst) begin
      m_valid = 0; m_sel = 0; m_done = 0; m_last = 3; m_left = 0;
    end else begin
      m_done = 0;
      if (m_valid != 0) begin
        if (m_left == 1 || !req[m_sel] || !en) begin
          m_done = 1;
          m_last = m_sel;
`ifdef RR_SEL_GAP_EN
          m_valid = 0;
`else
          w = pick(req, m_last);
          if (en && w >= 0) begin
            m_sel  = w;
            m_left = DWELL;
          end else begin
            m_valid = 0;
          end
`endif
        end else begin
          m_left = m_left - 1;
        end
      end else begin
        w = pick(req, m_last);
        if (en && w >= 0) begin
          m_valid = 1;
          m_sel   = w;
          m_left  = DWELL;
        end
      end
    end
  endtask

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    chk("valid", {3'b000, valid}, 4'(m_valid));
    chk("sel",   {2'b00, sel1, sel0}, 4'(m_sel));
    chk("done",  {3'b000, done}, 4'(m_done));
  endtask

  initial begin
    // reset and idle
    rst = 1'b1; en = 1'b0; req = 4'b0000;
    step(); step();
    rst = 1'b0; en = 1'b1;
    chk("rst_valid", {3'b000, valid}, 4'd0);
    chk("rst_sel",   {2'b00, sel1, sel0}, 4'd0);
    chk("rst_done",  {3'b000, done}, 4'd0);
    for (int i = 0; i < 10; i++) step();

    // all requesters: round-robin from channel 0
    req = 4'b1111;
    step();
    chk("first_grant_valid", {3'b000, valid}, 4'd1);
    chk("first_grant_sel",   {2'b00, sel1, sel0}, 4'd0);
    for (int i = 0; i < 22; i++) step();

    // single requester on channel 2
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step();
    req = 4'b0100;
    for (int i = 0; i < 14; i++) step();

    // early release on channel 1 with channel 3 pending
    req = 4'b0000;
    for (int i = 0; i < 3; i++) step();
    req = 4'b0010;
    step();
    chk("early_sel", {2'b00, sel1, sel0}, 4'd1);
    step(); step();
    req = 4'b1000;
    step();
    chk("early_done", {3'b000, done}, 4'd1);
    for (int i = 0; i < 6; i++) step();

    // reset during a grant
    req = 4'b1111;
    for (int i = 0; i < 3; i++) step();
    rst = 1'b1;
    step();
    chk("midrst_valid", {3'b000, valid}, 4'd0);
    chk("midrst_sel",   {2'b00, sel1, sel0}, 4'd0);
    chk("midrst_done",  {3'b000, done}, 4'd0);
    rst = 1'b0;
    step();
    chk("postrst_sel", {2'b00, sel1, sel0}, 4'd0);
    chk("postrst_valid", {3'b000, valid}, 4'd1);

    // en drops together with a request change
    step();
    en = 1'b0; req = 4'b0101;
    step();
    chk("endrop_valid", {3'b000, valid}, 4'd0);
    for (int i = 0; i < 3; i++) step();
    en = 1'b1;
    for (int i = 0; i < 6; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      en  = ($urandom_range(0, 9) != 0);
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
